// File: rtl/decoder_3to8_strobe_if.sv
// Transfer bus between the upstream encoder path and decoder_3to8_strobe.
// The master drives the code/valid request; the slave returns the strobe and status.
interface decoder_3to8_strobe_if;
  logic [2:0] y;
  logic       f;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] x;
  logic       x_valid;
  logic       busy;
  logic       err;
  logic [7:0] err_cnt;

  modport master (
    output y, f, in_valid,
    input  in_ready, x, x_valid, busy, err, err_cnt
  );

  modport slave (
    input  y, f, in_valid,
    output in_ready, x, x_valid, busy, err, err_cnt
  );
endinterface

// File: rtl/decoder_3to8_strobe.sv
// Registered 3-to-8 decoder: each accepted code drives a one-hot strobe for HOLD cycles,
// then GAP all-zero cycles. Transfers with f=0 are rejected, pulsed on err and counted.
module decoder_3to8_strobe #(
  parameter int unsigned HOLD = 4,
  parameter int unsigned GAP  = 1
) (
  input logic                  clk,
  input logic                  rst,
  decoder_3to8_strobe_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StHold, StGap} state_e;

  state_e     state_q;
  logic [7:0] cnt_q;
  logic [7:0] x_q;
  logic       err_q;
  logic [7:0] err_cnt_q;

  logic accept;
  assign accept = bus.in_valid && (state_q == StIdle);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= 8'h00;
      x_q       <= 8'h00;
      err_q     <= 1'b0;
      err_cnt_q <= 8'h00;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            if (bus.f) begin
              x_q     <= 8'h01 << bus.y;
              cnt_q   <= 8'(HOLD - 1);
              state_q <= StHold;
            end else begin
              // y is meaningless without f; only the reject is recorded.
              err_q <= 1'b1;
              if (err_cnt_q != 8'hff) begin
                err_cnt_q <= err_cnt_q + 8'h01;
              end
            end
          end
        end
        StHold: begin
          if (cnt_q == 8'h00) begin
            x_q <= 8'h00;
            if (GAP != 0) begin
              cnt_q   <= 8'(GAP - 1);
              state_q <= StGap;
            end else begin
              state_q <= StIdle;
            end
          end else begin
            cnt_q <= cnt_q - 8'h01;
          end
        end
        StGap: begin
          if (cnt_q == 8'h00) begin
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - 8'h01;
          end
        end
        default: begin
          state_q <= StIdle;
          x_q     <= 8'h00;
          cnt_q   <= 8'h00;
        end
      endcase
    end
  end

  // Status depends on registered state only, so no input reaches an output combinationally.
  assign bus.in_ready = (state_q == StIdle);
  assign bus.x_valid  = (state_q == StHold);
  assign bus.busy     = (state_q != StIdle);
  assign bus.x        = x_q;
  assign bus.err      = err_q;
  assign bus.err_cnt  = err_cnt_q;

endmodule
